// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_LIM = 2048;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    TURN      = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4
  } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Async-SRAM arbiter: video line fetches have priority, compute-engine
// writes get a forced slot once they have waited STARVE_LIM cycles.
// Reads are pipelined (address registered, data captured one cycle later);
// writes take a setup cycle and a single we_n strobe cycle.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk108,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int             CNT_W   = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             starved;
  logic             rd_pend_reg;

  // Writer has waited long enough that the next decision point must serve it.
  assign starved = (wait_cnt_reg == CNT_MAX);

  // State register.
  always_ff @(posedge clk108) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decision; TURN reuses the IDLE rules after its one dead cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, TURN: begin
        if (vid_req && !(starved && wr_valid)) begin
          state_next = RD;
        end else if (wr_valid) begin
          state_next = WR_SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        if (!vid_req || (wr_valid && starved)) begin
          state_next = TURN;
        end
      end
      WR_SETUP: begin
        state_next = WR_STROBE;
      end
      WR_STROBE: begin
        if (vid_req && !starved) begin
          state_next = TURN;
        end else if (wr_valid) begin
          state_next = WR_SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs; a write is accepted exactly when we head into WR_SETUP,
  // which is only ever chosen with wr_valid high.
  always_comb begin
    vid_gnt  = (state_reg == RD) && vid_req && !(wr_valid && starved);
    wr_ready = (state_next == WR_SETUP);
  end

  // Writer wait counter: counts stalled cycles, saturates, clears on accept.
  always_ff @(posedge clk108) begin
    if (rst) begin
      wait_cnt_reg <= '0;
    end else if (wr_ready) begin
      wait_cnt_reg <= '0;
    end else if (wr_valid && !starved) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Registered SRAM pins and read-return pipeline.
  always_ff @(posedge clk108) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      rd_pend_reg <= 1'b0;
      vid_valid   <= 1'b0;
      vid_data    <= '0;
    end else begin
      // Always full-word accesses once out of reset.
      sram_ce_n  <= 1'b0;
      sram_ub_n  <= 1'b0;
      sram_lb_n  <= 1'b0;
      // Output enable only in the cycle the granted address is on the bus.
      sram_oe_n  <= !vid_gnt;
      // Strobe only in WR_STROBE; address/data were loaded a cycle earlier.
      sram_we_n  <= (state_next != WR_STROBE);
      sram_dq_oe <= (state_next == WR_SETUP) || (state_next == WR_STROBE);
      if (vid_gnt) begin
        sram_addr <= vid_addr;
      end else if (wr_ready) begin
        sram_addr <= wr_addr;
        sram_dq_o <= wr_data;
      end
      rd_pend_reg <= vid_gnt;
      vid_valid   <= rd_pend_reg;
      if (rd_pend_reg) begin
        vid_data <= sram_dq_i;
      end
    end
  end

endmodule
